// File: rtl/avr_io_pkg.sv
// rtl/avr_io_pkg.sv - shared constants for the AVR-style I/O timer
// AVR_TIMER_OC_PIN_EN selects whether TCCR[6] (COM) is writable.
package avr_io_pkg;

  localparam logic [1:0] REG_TCCR = 2'd0;
  localparam logic [1:0] REG_TCNT = 2'd1;
  localparam logic [1:0] REG_OCR  = 2'd2;
  localparam logic [1:0] REG_TIFR = 2'd3;

  typedef enum logic [2:0] {
    CS_STOP    = 3'd0,
    CS_DIV1    = 3'd1,
    CS_DIV8    = 3'd2,
    CS_DIV64   = 3'd3,
    CS_DIV256  = 3'd4,
    CS_DIV1024 = 3'd5,
    CS_STOP6   = 3'd6,
    CS_STOP7   = 3'd7
  } cs_e;

  localparam int unsigned DIV_1    = 1;
  localparam int unsigned DIV_8    = 8;
  localparam int unsigned DIV_64   = 64;
  localparam int unsigned DIV_256  = 256;
  localparam int unsigned DIV_1024 = 1024;

  localparam int TCCR_CTC  = 3;
  localparam int TCCR_TOIE = 4;
  localparam int TCCR_OCIE = 5;
  localparam int TCCR_COM  = 6;
  localparam int TIFR_TOV  = 0;
  localparam int TIFR_OCF  = 1;

`ifdef AVR_TIMER_OC_PIN_EN
  localparam logic [7:0] TCCR_WMASK = 8'h3F | (8'd1 << TCCR_COM);
`else
  localparam logic [7:0] TCCR_WMASK = 8'h7F & ~(8'd1 << TCCR_COM);
`endif

  function automatic logic cs_running(input logic [2:0] cs);
    return (cs != CS_STOP) && (cs != CS_STOP6) && (cs != CS_STOP7);
  endfunction

  // Terminal prescaler count (divisor-1) for a running clock select.
  function automatic logic [9:0] cs_terminal(input logic [2:0] cs);
    case (cs)
      CS_DIV1:    return 10'(DIV_1 - 1);
      CS_DIV8:    return 10'(DIV_8 - 1);
      CS_DIV64:   return 10'(DIV_64 - 1);
      CS_DIV256:  return 10'(DIV_256 - 1);
      CS_DIV1024: return 10'(DIV_1024 - 1);
      default:    return 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/avr_timer_prescaler.sv
// rtl/avr_timer_prescaler.sv - 10-bit clock prescaler producing single-cycle ticks
module avr_timer_prescaler
  import avr_io_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cs,
  input  logic       clr,
  output logic       tick
);

  logic [9:0] r_cnt;
  logic       w_run;
  logic       w_at_top;

  assign w_run    = cs_running(cs);
  assign w_at_top = (r_cnt == cs_terminal(cs));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr || !w_run || w_at_top) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 10'd1;
    end
  end

  // A TCCR write cycle yields no tick so the new setting starts a full window.
  assign tick = w_run && w_at_top && !clr;

endmodule

// File: rtl/avr_io_timer.sv
// rtl/avr_io_timer.sv - 8-bit timer/counter on the CPU I/O bus
// Optional compare-output pin enabled by AVR_TIMER_OC_PIN_EN.
module avr_io_timer
  import avr_io_pkg::*;
#(
  parameter logic [5:0] BASE_ADDR = 6'h30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] io_addr,
  inout  tri   [7:0] io_data,
  input  logic       io_read,
  input  logic       io_write,
  output logic       irq
`ifdef AVR_TIMER_OC_PIN_EN
  ,
  output logic       oc_pin
`endif
);

  logic [7:0] r_tccr;
  logic [7:0] r_tcnt;
  logic [7:0] r_ocr;
  logic       r_tov;
  logic       r_ocf;

  logic       w_sel;
  logic       w_wr_tccr;
  logic       w_wr_tcnt;
  logic       w_wr_ocr;
  logic       w_wr_tifr;
  logic       w_tick;
  logic       w_count;
  logic       w_match;
  logic       w_ctc_clear;
  logic       w_ocf_set;
  logic       w_tov_set;
  logic       w_drive;
  logic [7:0] w_wdata;
  logic [7:0] w_rdata;

  assign w_sel     = (io_addr[5:2] == BASE_ADDR[5:2]);
  assign w_wdata   = io_data;
  assign w_wr_tccr = w_sel && io_write && (io_addr[1:0] == REG_TCCR);
  assign w_wr_tcnt = w_sel && io_write && (io_addr[1:0] == REG_TCNT);
  assign w_wr_ocr  = w_sel && io_write && (io_addr[1:0] == REG_OCR);
  assign w_wr_tifr = w_sel && io_write && (io_addr[1:0] == REG_TIFR);

  avr_timer_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .cs   (r_tccr[2:0]),
    .clr  (w_wr_tccr),
    .tick (w_tick)
  );

  // A CPU write to TCNT pre-empts the tick entirely (no count, no events).
  assign w_count     = w_tick && !w_wr_tcnt;
  assign w_match     = (r_tcnt == r_ocr);
  assign w_ctc_clear = r_tccr[TCCR_CTC] && w_match;
  assign w_ocf_set   = w_count && w_match;
  // Both the CTC clear at OCR=FF and a free-running FF->00 leave TCNT=FF behind.
  assign w_tov_set   = w_count && (r_tcnt == 8'hFF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tccr <= '0;
      r_ocr  <= '0;
    end else begin
      if (w_wr_tccr) r_tccr <= w_wdata & TCCR_WMASK;
      if (w_wr_ocr)  r_ocr  <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt <= '0;
    end else if (w_wr_tcnt) begin
      r_tcnt <= w_wdata;
    end else if (w_count) begin
      r_tcnt <= w_ctc_clear ? 8'h00 : r_tcnt + 8'd1;
    end
  end

  // Hardware set takes priority over a coincident write-1-to-clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tov <= 1'b0;
      r_ocf <= 1'b0;
    end else begin
      r_tov <= w_tov_set || (r_tov && !(w_wr_tifr && w_wdata[TIFR_TOV]));
      r_ocf <= w_ocf_set || (r_ocf && !(w_wr_tifr && w_wdata[TIFR_OCF]));
    end
  end

`ifdef AVR_TIMER_OC_PIN_EN
  logic r_oc_pin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oc_pin <= 1'b0;
    end else if (r_tccr[TCCR_COM] && w_ocf_set) begin
      r_oc_pin <= ~r_oc_pin;
    end
  end

  assign oc_pin = r_oc_pin;
`endif

  always_comb begin
    w_rdata = 8'h00;
    case (io_addr[1:0])
      REG_TCCR: w_rdata = r_tccr;
      REG_TCNT: w_rdata = r_tcnt;
      REG_OCR:  w_rdata = r_ocr;
      REG_TIFR: w_rdata = {6'b0, r_ocf, r_tov};
      default:  w_rdata = 8'h00;
    endcase
  end

  assign w_drive = w_sel && io_read && !io_write;
  assign io_data = w_drive ? w_rdata : 8'bz;

  assign irq = (r_tov && r_tccr[TCCR_TOIE]) || (r_ocf && r_tccr[TCCR_OCIE]);

endmodule

// File: doc/avr_io_timer.md
Name: avr_io_timer

Overview:
- 8-bit timer/counter peripheral; the responder side of the CPU I/O bus (io_addr / io_data / io_read / io_write) driven by the execute stage.
- Provides four I/O registers: control, count, compare and flags.
- Provides a level interrupt request.
- Multiple instances share the bus at different base addresses.

Parameters:
- BASE_ADDR, 6'h30, I/O address of register 0; must be 4-aligned. Map: +0 TCCR, +1 TCNT, +2 OCR, +3 TIFR.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- io_addr  in  6  I/O register address from CPU
- io_data  inout  8  bidirectional data; driven only during a selected read, else high-Z
- io_read  in  1  CPU read strobe; combinational read, same cycle
- io_write  in  1  CPU write strobe; data captured at the rising edge ending the cycle
- irq  out  1  interrupt request = (TOV & TOIE) | (OCF & OCIE)

Behaviour:
- Select: sel = (io_addr[5:2] == BASE_ADDR[5:2]).
- Read path: io_data = register[io_addr[1:0]] when sel & io_read & !io_write, else 8'bZ.
  - Zero latency; value is the pre-edge register content.
  - Unmapped bits read 0.
- TCCR layout:
  - [2:0] CS clock select: 0 stopped, 1 clk/1, 2 /8, 3 /64, 4 /256, 5 /1024, 6-7 stopped.
  - [3] CTC; [4] TOIE; [5] OCIE; [7:6] reserved, read 0.
- TIFR layout: [0] TOV, [1] OCF; write-1-to-clear; writing 0 has no effect.
- Prescaler:
  - 10-bit free-running counter.
  - tick = 1 for one clk when the counter reaches divisor-1; the counter then returns to 0.
  - CS=1: tick every cycle.
  - Any TCCR write clears the prescaler.
  - Stopped: no ticks, prescaler held at 0.
- Counter, on each tick with no TCNT write that cycle:
  - match = (TCNT == OCR).
  - CTC=1 and match: TCNT <= 0, OCF set. If OCR == 8'hFF, TOV is also set.
  - Otherwise: TCNT <= TCNT + 1 mod 256. Transition FF->00 sets TOV. A match sets OCF.
- Simultaneous events:
  - CPU write to TCNT in a tick cycle: the written value wins; no increment, no match/TOV that cycle.
  - CPU write to OCR in a tick cycle: the compare uses the old OCR.
  - Flag set and write-1-clear of the same flag in one cycle: the set wins.
- irq: registered-flag combinational; asserts the cycle after the flag sets, deasserts the cycle after clear or enable-off.
- Reset (asynchronous, any time incl. mid-count):
  - TCCR=0, TCNT=0, OCR=0, TIFR=0, prescaler=0.
  - irq=0; io_data high-Z.
- Writes with io_read and io_write both high: the write proceeds, no drive.

Optional Feature:
- Macro AVR_TIMER_OC_PIN_EN.
- Enabled:
  - Adds port oc_pin out 1, reset 0.
  - TCCR[6] becomes COM; when COM=1, oc_pin toggles on each compare-match event, registered.
  - Writing COM=0 holds oc_pin at its current value.
- Disabled: no oc_pin port; TCCR[6] reserved, reads 0, writes ignored.

Decomposition:
- Shared package avr_io_pkg holds:
  - Register offsets TCCR/TCNT/OCR/TIFR.
  - CS encodings and divisor constants.
  - Bit positions CTC, TOIE, OCIE, COM, TOV, OCF.
- One sub-module, avr_timer_prescaler:
  - Inputs clk, rst, cs, clr.
  - Output tick; owns the 10-bit counter.
- The top module holds the bus decode, registers, counter and flags.

Test Plan:
1. Reset then read all four addresses -> 8'h00 each.
   - Read at address 6'h2F (outside the map) -> io_data high-Z.
2. Write OCR=8'h03, TCCR=8'h09 (CS=1, CTC) -> TCNT sequence 0,1,2,3,0,…
   - OCF=1 after the first 3->0 wrap; TOV stays 0.
3. Write TCNT=8'hFE, TCCR=8'h11 (CS=1, TOIE) -> TOV set 2 cycles later, irq=1 the next cycle.
   - Write TIFR=8'h01 -> TOV=0, irq=0.
4. TCCR=8'h02 (/8) -> TCNT increments exactly once per 8 clk.
   - TCCR rewrite mid-period restarts the 8-cycle window.
5. Write TCNT=8'h40 in a tick cycle -> TCNT reads 8'h40 (no 8'h41).
   - Write-1-clear of OCF coincident with a match -> OCF reads 1.
6. Assert rst mid-count with TCNT=8'h7A, flags set -> all registers 0 and irq=0 immediately, without a clk edge.
